// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_pkg
// Brief    : State encodings and bus constants shared by the fetch sequencer.
// Revision : 1.0
// ============================================================================
package fetch_pc_ctrl_pkg;

    localparam int          C_PC_W     = 64;
    localparam int          C_INST_W   = 32;
    localparam logic [63:0] C_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        FC_BOOT  = 3'd0,
        FC_REQ   = 3'd1,
        FC_FLUSH = 3'd2,
        FC_PRED  = 3'd3,
        FC_HOLD  = 3'd4
    } fc_state_t;

endpackage : fetch_pc_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_pc_ctrl_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_out_buf
// Brief    : Single-entry valid/ready slice holding the predicted instruction
//            for decode; flush drops the entry.
// Revision : 1.0
// ============================================================================
module fetch_out_buf #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic [PC_W-1:0]   ld_pc,
    input  logic [INST_W-1:0] ld_inst,
    input  logic [PC_W-1:0]   ld_pred_pc,
    input  logic              ready,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pred_pc
);

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_pred_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_inst    <= '0;
            r_pred_pc <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid   <= 1'b1;
            r_pc      <= ld_pc;
            r_inst    <= ld_inst;
            r_pred_pc <= ld_pred_pc;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid   = r_valid;
    assign pc      = r_pc;
    assign inst    = r_inst;
    assign pred_pc = r_pred_pc;

endmodule : fetch_out_buf
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Brief    : IF-stage sequencer: owns the fetch PC, runs the req/ack fetch,
//            steers through the static predictor and hands off to decode.
// Revision : 1.0
// ============================================================================
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int              PC_W     = C_PC_W,
    parameter int              INST_W   = C_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(C_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fetch_req,
    output logic [PC_W-1:0]   fetch_addr,
    input  logic              fetch_ack,
    input  logic [INST_W-1:0] fetch_inst,
    output logic [PC_W-1:0]   pred_pc_i,
    output logic [INST_W-1:0] pred_inst,
    input  logic [PC_W-1:0]   pred_pc_o,
    input  logic              pred_x1_ena,
    input  logic              x1_busy,
    input  logic              trap_vld,
    input  logic [PC_W-1:0]   trap_pc,
    input  logic              ex_redir_vld,
    input  logic [PC_W-1:0]   ex_redir_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pred_pc
);

    localparam logic [PC_W-1:0] C_ALIGN_MASK = ~PC_W'(3);

    fc_state_t         r_state;
    logic [PC_W-1:0]   r_pc_q;
    logic [PC_W-1:0]   r_fetch_addr;
    logic              r_fetch_req;
    logic [PC_W-1:0]   r_cur_pc;
    logic [INST_W-1:0] r_cur_inst;

    logic              w_redir;
    logic [PC_W-1:0]   w_redir_raw;
    logic [PC_W-1:0]   w_redir_pc;
    logic              w_x1_stall;
    logic              w_in_pred;
    logic              w_buf_free;
    logic              w_load;
    logic              w_flush;

    // Trap outranks the execute-stage correction; targets are word aligned.
    assign w_redir     = trap_vld | ex_redir_vld;
    assign w_redir_raw = trap_vld ? trap_pc : ex_redir_pc;
    assign w_redir_pc  = w_redir_raw & C_ALIGN_MASK;

    assign w_x1_stall = pred_x1_ena & x1_busy;
    assign w_in_pred  = (r_state == FC_PRED) || (r_state == FC_HOLD);
    assign w_buf_free = ~id_valid | id_ready;
    assign w_load     = w_in_pred & ~w_redir & ~w_x1_stall & w_buf_free;
    assign w_flush    = w_redir & (r_state != FC_BOOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FC_BOOT;
            r_pc_q       <= RESET_PC;
            r_fetch_req  <= 1'b0;
            r_fetch_addr <= RESET_PC;
            r_cur_pc     <= '0;
            r_cur_inst   <= '0;
        end else begin
            unique case (r_state)
                FC_BOOT: begin
                    r_state      <= FC_REQ;
                    r_fetch_req  <= 1'b1;
                    r_fetch_addr <= r_pc_q;
                end
                FC_REQ: begin
                    if (w_redir) begin
                        r_pc_q <= w_redir_pc;
                        // An ack coinciding with the redirect is discarded
                        // and the new fetch starts immediately.
                        if (fetch_ack) begin
                            r_fetch_addr <= w_redir_pc;
                        end else begin
                            r_state <= FC_FLUSH;
                        end
                    end else if (fetch_ack) begin
                        r_cur_inst  <= fetch_inst;
                        r_cur_pc    <= r_pc_q;
                        r_fetch_req <= 1'b0;
                        r_state     <= FC_PRED;
                    end
                end
                FC_FLUSH: begin
                    if (w_redir) begin
                        r_pc_q <= w_redir_pc;
                    end
                    if (fetch_ack) begin
                        r_state      <= FC_REQ;
                        r_fetch_addr <= w_redir ? w_redir_pc : r_pc_q;
                    end
                end
                FC_PRED, FC_HOLD: begin
                    if (w_redir) begin
                        r_pc_q       <= w_redir_pc;
                        r_fetch_addr <= w_redir_pc;
                        r_fetch_req  <= 1'b1;
                        r_cur_inst   <= '0;
                        r_state      <= FC_REQ;
                    end else if (w_load) begin
                        r_pc_q       <= pred_pc_o;
                        r_fetch_addr <= pred_pc_o;
                        r_fetch_req  <= 1'b1;
                        r_state      <= FC_REQ;
                    end else if (!w_x1_stall) begin
                        r_state <= FC_HOLD;
                    end
                end
                default: begin
                    r_state     <= FC_BOOT;
                    r_fetch_req <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req  = r_fetch_req;
    assign fetch_addr = r_fetch_addr;
    assign pred_pc_i  = r_cur_pc;
    assign pred_inst  = r_cur_inst;

    fetch_out_buf #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (w_flush),
        .load       (w_load),
        .ld_pc      (r_cur_pc),
        .ld_inst    (r_cur_inst),
        .ld_pred_pc (pred_pc_o),
        .ready      (id_ready),
        .valid      (id_valid),
        .pc         (id_pc),
        .inst       (id_inst),
        .pred_pc    (id_pred_pc)
    );

endmodule : fetch_pc_ctrl
`default_nettype wire
